// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2,
    ERROR = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  // Jump target = {pcplus4[31:28], instr[25:0], 2'b00}
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_W     = JIDX_MSB + 1;
  localparam int REGION_MSB = 31;
  localparam int REGION_LSB = 28;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: jump target over taken branch over sequential pc+4.
module pc_next
  import fetch_pkg::*;
(
  input  logic [31:0]        pcplus4_i,
  input  logic [JIDX_W-1:0]  jidx_i,
  input  logic signed [31:0] signimm_i,
  input  logic               pcsrc_i,
  input  logic               jump_i,
  output logic [31:0]        pc_next_o
);

  logic signed [31:0] br_off;
  logic [31:0]        br_target;
  logic [31:0]        j_target;

  // Word offset scaled to bytes; the sum wraps modulo 2^32.
  assign br_off    = signimm_i <<< 2;
  assign br_target = pcplus4_i + $unsigned(br_off);
  assign j_target  = {pcplus4_i[REGION_MSB:REGION_LSB], jidx_i, 2'b00};

  always_comb begin
    pc_next_o = pcplus4_i;
    if (jump_i) begin
      pc_next_o = j_target;
    end else if (pcsrc_i) begin
      pc_next_o = br_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, memory request handshake with a
// timeout watchdog, and a held instruction slot presented to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        fetch_err
);

  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};
  localparam logic [7:0]  WAIT_LAST  = 8'(MAX_WAIT - 1);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  instr_q;
  logic [7:0]   wait_cnt_q;
  logic         imem_req_q;
  logic         instr_valid_q;
  logic         fetch_err_q;

  assign pcplus4     = pc_q + 32'd4;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

  pc_next u_pc_next (
    .pcplus4_i (pcplus4),
    .jidx_i    (instr_q[JIDX_MSB:0]),
    .signimm_i (signed'(signimm)),
    .pcsrc_i   (pcsrc),
    .jump_i    (jump),
    .pc_next_o (pc_d)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC_A;
      instr_q       <= NOP;
      wait_cnt_q    <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= REQ;
          imem_req_q <= 1'b1;
        end
        REQ: begin
          // A response in the last allowed cycle still wins over the timeout.
          if (imem_valid) begin
            instr_q       <= imem_rdata;
            wait_cnt_q    <= '0;
            state_q       <= ISSUE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q     <= ERROR;
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            pc_q          <= pc_d;
            state_q       <= REQ;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level PC model.
module tb_fetch_unit;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        fetch_err;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .signimm     (signimm),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_ctrl();
    pcsrc   = 1'($urandom);
    jump    = 1'($urandom);
    signimm = $urandom;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic ps, input logic jp,
                                             input logic [31:0] simm);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    if (ps) return seq + simm * 32'd4;
    return seq;
  endfunction

  task automatic do_reset();
    reset_n     = 1'b0;
    imem_valid  = 1'b0;
    instr_ready = 1'b0;
    imem_rdata  = $urandom;
    junk_ctrl();
    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", imem_req, 0);
    chk("rst_iv", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_instr", instr, 32'h0);
    reset_n = 1'b1;
    tick();
    chk("rel_req", imem_req, 1);
    chk("rel_addr", imem_addr, 32'h0);
    m_pc = 32'h0;
  endtask

  // One full transaction: wait delay cycles, deliver word, stall, then accept.
  task automatic fetch(input int delay, input logic [31:0] word, input int stall,
                       input logic ps, input logic jp, input logic [31:0] simm);
    chk("req_on", imem_req, 1);
    chk("addr", imem_addr, m_pc);
    chk("pcplus4", pcplus4, m_pc + 32'd4);
    for (int i = 0; i < delay; i++) begin
      imem_valid  = 1'b0;
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom);
      junk_ctrl();
      tick();
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, m_pc);
      chk("iv_wait", instr_valid, 0);
      chk("err_wait", fetch_err, 0);
    end
    imem_valid  = 1'b1;
    imem_rdata  = word;
    instr_ready = 1'($urandom);
    junk_ctrl();
    tick();
    chk("instr", instr, word);
    chk("iv", instr_valid, 1);
    chk("req_off", imem_req, 0);
    for (int i = 0; i < stall; i++) begin
      imem_valid  = 1'($urandom);
      imem_rdata  = $urandom;
      instr_ready = 1'b0;
      junk_ctrl();
      tick();
      chk("stall_instr", instr, word);
      chk("stall_iv", instr_valid, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_pc", pc, m_pc);
    end
    imem_valid  = 1'b0;
    instr_ready = 1'b1;
    pcsrc       = ps;
    jump        = jp;
    signimm     = simm;
    tick();
    instr_ready = 1'b0;
    m_pc = model_next(m_pc, word, ps, jp, simm);
    chk("iv_drop", instr_valid, 0);
    chk("req_next", imem_req, 1);
    chk("pc_next", pc, m_pc);
    chk("addr_next", imem_addr, m_pc);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] w;
    do_reset();

    fetch(0, 32'h2008_0005, 0, 1'b0, 1'b0, 32'h0);
    chk("seq_pc4", pc, 32'h4);
    fetch(0, 32'h0800_0004, 0, 1'b0, 1'b1, 32'h0);
    chk("jmp_0x10", pc, 32'h10);
    w = $urandom;
    fetch(1, w, 0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    chk("br_back", pc, 32'h0C);
    w = $urandom;
    fetch(0, w, 0, 1'b0, 1'b0, 32'h0);
    w = $urandom;
    fetch(2, w, 0, 1'b0, 1'b0, 32'hFFFF_FFFE);
    chk("br_not_taken", pc, 32'h14);
    fetch(0, 32'h0800_0010, 0, 1'b0, 1'b1, 32'h0);
    fetch(0, 32'h0800_0010, 0, 1'b1, 1'b1, $urandom);
    chk("jump_wins", pc, 32'h40);
    w = $urandom;
    fetch(0, w, 5, 1'b0, 1'b0, 32'h0);
    chk("bp_pc", pc, 32'h44);
    w = $urandom;
    fetch(MAX_WAIT - 1, w, 0, 1'b0, 1'b0, 32'h0);

    for (int k = 0; k < 150; k++) begin
      int d;
      d = (k % 7 == 0) ? MAX_WAIT - 1 : int'($urandom_range(3, 0));
      fetch(d, $urandom, int'($urandom_range(3, 0)), 1'($urandom),
            ($urandom_range(3, 0) == 0), $urandom);
    end

    // Reset while a request is outstanding, with a late response.
    imem_valid = 1'b0;
    tick();
    tick();
    reset_n    = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = $urandom;
    tick();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_iv", instr_valid, 0);
    chk("mid_rst_instr", instr, 32'h0);
    reset_n = 1'b1;
    tick();
    chk("mid_rel_req", imem_req, 1);
    chk("mid_rel_iv", instr_valid, 0);
    imem_valid = 1'b0;
    m_pc = 32'h0;
    fetch(0, $urandom, 0, 1'b0, 1'b0, 32'h0);
    chk("mid_rel_pc", pc, 32'h4);

    // Timeout: never answer the request.
    imem_valid = 1'b0;
    n = imem_req ? 1 : 0;
    for (int i = 0; i < 100 && imem_req; i++) begin
      tick();
      if (imem_req) n++;
    end
    chk("timeout_len", n, MAX_WAIT);
    chk("err_set", fetch_err, 1);
    for (int i = 0; i < 5; i++) begin
      imem_valid  = 1'($urandom);
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom);
      tick();
      chk("err_hold", fetch_err, 1);
      chk("err_req", imem_req, 0);
      chk("err_iv", instr_valid, 0);
    end
    do_reset();
    chk("err_clr", fetch_err, 0);
    fetch(0, 32'h2008_0005, 0, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
